cycle_sequencer: RTL
====================

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 Parameter: WORD, 16, datapath/address width in bits.
REQ-002 Parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-003 Parameter: FETCH_TIMEOUT, 8, maximum WAIT cycles before the fault state; legal range 1..255.
REQ-004 Port: clk  input  1  single clock; all state updates on posedge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: run  input  1  start/continue request; sampled in IDLE.
REQ-007 Port: halt_req  input  1  stop after the current instruction completes.
REQ-008 Port: mem_ready  input  1  instruction memory acknowledge for fetch.
REQ-009 Port: jump, mem_wb, reg_wb, flag_update  input  1 each  execute-stage result strobes.
REQ-010 Port: PC_jump_loc, PC_jump_inc  input  WORD each  execute-stage absolute target / relative increment.
REQ-011 Port: pc  output  WORD  current program counter; drives the fetch address.
REQ-012 Port: fetch_req  output  1  fetch request, held until acknowledged.
REQ-013 Port: dne_tr  output  1  one-cycle execute enable.
REQ-014 Port: reg_we, mem_we, sreg_we  output  1 each  one-cycle write-back commits.
REQ-015 Port: busy  output  1  high in every state except IDLE and HALT.
REQ-016 Port: fault  output  1  sticky fetch-timeout indicator.
REQ-017 Port: retired  output  WORD  count of completed instructions.

Function
REQ-018 FSM states: IDLE, FETCH, WAIT, EXEC, SETTLE, WB, HALT, FAULT.
REQ-019 IDLE: go to FETCH when run=1; otherwise stay.
REQ-020 FETCH: assert fetch_req; go to EXEC if mem_ready=1 in the same cycle, else go to WAIT.
REQ-021 WAIT: hold fetch_req=1 with pc stable; go to EXEC on mem_ready=1; go to FAULT on the FETCH_TIMEOUT-th consecutive WAIT cycle with mem_ready=0.
REQ-022 fetch_req is deasserted in every state other than FETCH and WAIT.
REQ-023 EXEC: dne_tr=1 for exactly one cycle; always go to SETTLE.
REQ-024 SETTLE: no outputs asserted; provides one cycle for the execute stage's registered results; go to WB.
REQ-025 WB: reg_we=reg_wb, mem_we=mem_wb and sreg_we=flag_update, each for this cycle only.
REQ-026 WB PC update: pc <= PC_jump_loc if jump=1, else pc + PC_jump_inc truncated to WORD bits (wraps modulo 2^WORD).
REQ-027 PC_jump_inc=0 with jump=0 leaves pc unchanged; this is legal and the instruction refetches.
REQ-028 WB increments retired by 1 (wraps modulo 2^WORD).
REQ-029 WB next state: HALT if halt_req=1 in WB or latched since the last FETCH; else FETCH if run=1; else IDLE.
REQ-030 halt_req asserted in any state is latched and acted on only at WB; an in-flight instruction always completes.
REQ-031 HALT and FAULT are exited only by rst; pc and retired hold their values.
REQ-032 FAULT sets fault=1 and performs no write-back.
REQ-033 Minimum instruction period is 4 cycles (FETCH, EXEC, SETTLE, WB) with zero-wait memory.

Reset
REQ-034 On rst=1 at posedge: state=IDLE, pc=RESET_PC, retired=0, fault=0, halt latch=0; fetch_req, dne_tr, reg_we, mem_we, sreg_we and busy are 0.
REQ-035 rst has priority over every other input in every state, including mid-WAIT and WB; no write-back strobe is issued in the reset cycle.

Verification
REQ-036 Reset, run=1, mem_ready=1, each instruction returns jump=0 and PC_jump_inc=1 -> pc sequence 0,1,2; dne_tr pulses every 4 cycles; retired=3 after 12 cycles.
REQ-037 Result jump=1, PC_jump_loc=16'h0040, reg_wb=1 -> pc=16'h0040 after WB; reg_we high for exactly one cycle.
REQ-038 pc=16'hFFFF, PC_jump_inc=2, jump=0 -> pc=16'h0001 after WB.
REQ-039 mem_ready held low for 3 cycles, then high -> fetch_req stays high for 4 cycles and pc stays stable; mem_ready never asserted -> fault=1 after 8 WAIT cycles, state FAULT, and no dne_tr.
REQ-040 halt_req pulsed during EXEC -> WB completes with commits issued, then HALT; busy=0; no further fetch_req until rst.
REQ-041 rst asserted during WAIT -> next cycle state=IDLE, pc=RESET_PC, fetch_req=0, retired=0.

Source files
------------

// File: rtl/cycle_sequencer.sv
// cycle_sequencer
// Instruction-cycle controller for a simple single-issue core. It runs the
// sequence FETCH -> (WAIT)* -> EXEC -> SETTLE -> WB, owns the program
// counter and retired-instruction counter, and issues the one-cycle
// execute enable and write-back commit strobes.
//
// Handshake: fetch_req is a valid-style request that is held, with pc
// stable, until mem_ready is seen high on a rising edge while fetch_req is
// high. mem_ready is only looked at in FETCH and WAIT. No other
// valid/ready pairs exist on this block.
//
// Parameters
//   WORD          datapath / address width
//   RESET_PC      pc value loaded by reset
//   FETCH_TIMEOUT consecutive not-ready WAIT cycles that trip FAULT (1..255)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   run                      start/continue request (IDLE and WB)
//   halt_req                 stop after the in-flight instruction retires
//   mem_ready                instruction memory acknowledge
//   jump, mem_wb, reg_wb,
//   flag_update              execute-stage result strobes (used in WB)
//   PC_jump_loc, PC_jump_inc absolute target / relative increment (WB)
//   pc                       program counter, drives the fetch address
//   fetch_req                fetch request
//   dne_tr                   one-cycle execute enable
//   reg_we, mem_we, sreg_we  one-cycle write-back commits
//   busy                     high except in IDLE and HALT
//   fault                    sticky fetch-timeout indicator
//   retired                  completed instruction count
//   state_dbg                current FSM state encoding (debug visibility)

module cycle_sequencer #(
  parameter int              WORD          = 16,
  parameter logic [WORD-1:0] RESET_PC      = '0,
  parameter int              FETCH_TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            halt_req,
  input  logic            mem_ready,
  input  logic            jump,
  input  logic            mem_wb,
  input  logic            reg_wb,
  input  logic            flag_update,
  input  logic [WORD-1:0] PC_jump_loc,
  input  logic [WORD-1:0] PC_jump_inc,
  output logic [WORD-1:0] pc,
  output logic            fetch_req,
  output logic            dne_tr,
  output logic            reg_we,
  output logic            mem_we,
  output logic            sreg_we,
  output logic            busy,
  output logic            fault,
  output logic [WORD-1:0] retired,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_EXEC   = 3'd3,
    S_SETTLE = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  // Last WAIT cycle before the timeout trips: the FETCH_TIMEOUT-th
  // consecutive not-ready WAIT cycle sees wait_cnt == FETCH_TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t     state;
  state_t     state_n;
  logic [7:0] wait_cnt;
  logic       halt_lat;

  assign state_dbg = state;

  // Next-state and outputs
  always_comb begin
    state_n   = state;
    fetch_req = 1'b0;
    dne_tr    = 1'b0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    sreg_we   = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (run) state_n = S_FETCH;
      end
      S_FETCH: begin
        fetch_req = 1'b1;
        state_n   = mem_ready ? S_EXEC : S_WAIT;
      end
      S_WAIT: begin
        fetch_req = 1'b1;
        if (mem_ready)                   state_n = S_EXEC;
        else if (wait_cnt == WAIT_LAST)  state_n = S_FAULT;
      end
      S_EXEC: begin
        dne_tr  = 1'b1;
        state_n = S_SETTLE;
      end
      S_SETTLE: begin
        state_n = S_WB;
      end
      S_WB: begin
        // Commits are suppressed while reset is asserted so a WB cycle
        // that coincides with reset writes nothing back.
        reg_we  = reg_wb & ~rst;
        mem_we  = mem_wb & ~rst;
        sreg_we = flag_update & ~rst;
        if (halt_req || halt_lat) state_n = S_HALT;
        else if (run)             state_n = S_FETCH;
        else                      state_n = S_IDLE;
      end
      S_HALT: begin
        busy = 1'b0;
      end
      S_FAULT: begin
        // Terminal until reset; no write-back.
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counters and architectural registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      halt_lat <= 1'b0;
      pc       <= RESET_PC;
      retired  <= '0;
      fault    <= 1'b0;
    end else begin
      state <= state_n;
      // Counts consecutive not-ready WAIT cycles; cleared outside WAIT.
      if (state == S_WAIT) wait_cnt <= wait_cnt + 8'd1;
      else                 wait_cnt <= '0;
      // Halt requests are remembered until reset; only WB acts on them.
      halt_lat <= halt_lat | halt_req;
      if (state == S_WB) begin
        pc      <= jump ? PC_jump_loc : pc + PC_jump_inc;
        retired <= retired + 1'b1;
      end
      if (state_n == S_FAULT) fault <= 1'b1;
    end
  end

endmodule
